// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode
// Brief    : Fetch/decode/execute sequencer with 16x8 instruction memory for
//            the 4-bit CPU. Optional FETCH_ICOUNT_EN adds a saturating
//            retired-instruction counter on output icount.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_decode #(
  parameter int IMEM_DEPTH = 16,
  parameter int PC_W       = 4,
  parameter int INSTR_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_curr,
  input  logic               zero_flag,
  input  logic               stall,
  input  logic               imem_we,
  input  logic [PC_W-1:0]    imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         operand,
  output logic               exec_valid,
  output logic               pc_step,
  output logic               pc_jump,
  output logic [PC_W-1:0]    pc_target,
`ifdef FETCH_ICOUNT_EN
  output logic [7:0]         icount,
`endif
  output logic               halted
);

  localparam logic [3:0] c_op_halt = 4'hF;
  localparam logic [3:0] c_op_jmp  = 4'hE;
  localparam logic [3:0] c_op_jz   = 4'hD;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  state_t             r_state;
  logic [INSTR_W-1:0] r_ir;
  logic [PC_W-1:0]    r_pc_target;
  logic               r_halted;
  logic [INSTR_W-1:0] r_mem [IMEM_DEPTH];

  logic [INSTR_W-1:0] w_rdata;
  logic               w_exec;
  logic               w_take_jump;
  logic               w_jump_class;

  // Memory is deliberately outside the reset domain: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      r_mem[imem_waddr] <= imem_wdata;
    end
  end

  assign w_rdata = r_mem[pc_curr];

  assign opcode  = r_ir[INSTR_W-1 -: 4];
  assign operand = r_ir[3:0];

  assign w_jump_class = (opcode == c_op_jmp) || (opcode == c_op_jz);
  assign w_take_jump  = (opcode == c_op_jmp) || ((opcode == c_op_jz) && zero_flag);

  // Strobes follow stall combinationally so a stalled EXEC defers, not drops, them.
  assign w_exec     = (r_state == S_EXEC) && !stall;
  assign exec_valid = w_exec;
  assign pc_jump    = w_exec && w_take_jump;
  assign pc_step    = w_exec && !w_take_jump && (opcode != c_op_halt);

  assign ir        = r_ir;
  assign pc_target = r_pc_target;
  assign halted    = r_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_ir        <= '0;
      r_pc_target <= '0;
      r_halted    <= 1'b0;
    end else if (!stall) begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= w_rdata;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (w_jump_class) begin
            r_pc_target <= operand[PC_W-1:0];
          end
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (opcode == c_op_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_state  <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_ICOUNT_EN
  logic [7:0] r_icount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_icount <= 8'h00;
    end else if (w_exec && (r_icount != 8'hFF)) begin
      r_icount <= r_icount + 8'd1;
    end
  end

  assign icount = r_icount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode
// Brief    : Self-checking bench for fetch_decode; the bench plays the PC stage
//            and predicts each instruction from a memory image and opcode rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pc_curr = 4'h0;
  logic       zero_flag = 1'b0;
  logic       stall = 1'b0;
  logic       imem_we = 1'b0;
  logic [3:0] imem_waddr = 4'h0;
  logic [7:0] imem_wdata = 8'h00;
  logic [7:0] ir;
  logic [3:0] opcode, operand, pc_target;
  logic       exec_valid, pc_step, pc_jump, halted;
`ifdef FETCH_ICOUNT_EN
  logic [7:0] icount;
`endif

  fetch_decode dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_curr    (pc_curr),
    .zero_flag  (zero_flag),
    .stall      (stall),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .ir         (ir),
    .opcode     (opcode),
    .operand    (operand),
    .exec_valid (exec_valid),
    .pc_step    (pc_step),
    .pc_jump    (pc_jump),
    .pc_target  (pc_target),
`ifdef FETCH_ICOUNT_EN
    .icount     (icount),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] ref_mem [16];
  bit         model_halted = 1'b0;
  int         exp_icount = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_icount();
`ifdef FETCH_ICOUNT_EN
    check("icount", icount, (exp_icount > 255) ? 255 : exp_icount);
`endif
  endtask

  // Called at posedge+1; writes one memory word over one clock.
  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(posedge clk); #1;
    imem_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_halted = 1'b0;
    exp_icount = 0;
    check("rst_ir", ir, 8'h00);
    check("rst_pc_target", pc_target, 4'h0);
    check("rst_exec_valid", exec_valid, 1'b0);
    check("rst_pc_step", pc_step, 1'b0);
    check("rst_pc_jump", pc_jump, 1'b0);
    check("rst_halted", halted, 1'b0);
    check_icount();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // stall_mode: 0 none, 1 random, 2 four stall cycles on arrival at EXEC.
  // zf_mode: 0 zero_flag=0, 1 zero_flag=1, 2 random.
  task automatic run_instr(input int stall_mode, input int zf_mode,
                           input bit wr_fetch, input logic [7:0] wdata);
    logic [7:0] exp_ir;
    logic [3:0] op;
    bit ex, jmp, stp, do_wr;
    int k, nstall, guard;
    exp_ir = ref_mem[pc_curr];
    op = exp_ir[7:4];
    do_wr = wr_fetch;
    k = 0; nstall = 0; guard = 0;
    while (k < 3 && guard < 40) begin
      guard++;
      case (stall_mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (k == 2) && (nstall < 4);
        default: stall = 1'b0;
      endcase
      if (stall) nstall++;
      zero_flag = (zf_mode == 2) ? ($urandom_range(0, 1) == 1) : (zf_mode == 1);
      imem_we = do_wr && (k == 0);
      imem_waddr = pc_curr;
      imem_wdata = wdata;
      #2;
      ex  = !stall && (k == 2);
      jmp = ex && ((op == 4'hE) || ((op == 4'hD) && zero_flag));
      stp = ex && !jmp && (op != 4'hF);
      check("exec_valid", exec_valid, ex);
      check("pc_step", pc_step, stp);
      check("pc_jump", pc_jump, jmp);
      if (jmp) check("pc_target", pc_target, exp_ir[3:0]);
      if (k > 0) begin
        check("ir", ir, exp_ir);
        check("opcode", opcode, exp_ir[7:4]);
        check("operand", operand, exp_ir[3:0]);
      end
      check("halted", halted, model_halted);
      check_icount();
      @(posedge clk); #1;
      if (imem_we) begin
        ref_mem[imem_waddr] = imem_wdata;
        imem_we = 1'b0;
        do_wr = 1'b0;
      end
      if (!stall) k++;
      if (ex) begin
        exp_icount++;
        if (op == 4'hF) model_halted = 1'b1;
      end
      if (jmp) pc_curr = exp_ir[3:0];
      else if (stp) pc_curr = pc_curr + 4'h1;
    end
    if (k < 3) check("instr_timeout", 32'd0, 32'd1);
    stall = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h00);
    wr(4'h0, 8'h12); wr(4'h1, 8'h34); wr(4'h2, 8'hD5); wr(4'h3, 8'hF0);
    wr(4'h9, 8'h5A); wr(4'hA, 8'hE0);
    do_reset();

    // Plain sequential instructions, back to back.
    pc_curr = 4'h0;
    run_instr(0, 0, 1'b0, 8'h00);
    run_instr(0, 0, 1'b0, 8'h00);
    check("pc_after_two", pc_curr, 4'h2);

    // JZ taken, then not taken.
    run_instr(0, 1, 1'b0, 8'h00);
    check("jz_taken_pc", pc_curr, 4'h5);
    pc_curr = 4'h2;
    run_instr(0, 0, 1'b0, 8'h00);
    check("jz_not_taken_pc", pc_curr, 4'h3);

    // HALT is sticky; memory still writable while halted.
    run_instr(0, 2, 1'b0, 8'h00);
    for (int c = 0; c < 20; c++) begin
      zero_flag = ($urandom_range(0, 1) == 1);
      #2;
      check("halt_exec_valid", exec_valid, 1'b0);
      check("halt_pc_step", pc_step, 1'b0);
      check("halt_pc_jump", pc_jump, 1'b0);
      check("halt_halted", halted, 1'b1);
      check("halt_ir", ir, 8'hF0);
      @(posedge clk); #1;
    end
    wr(4'h4, 8'hE9);
    check("halt_ir_after_write", ir, 8'hF0);
    do_reset();

    // JMP after leaving HALT via reset.
    pc_curr = 4'h4;
    run_instr(0, 2, 1'b0, 8'h00);
    check("jmp_pc", pc_curr, 4'h9);

    // Four-cycle stall parked in EXEC.
    run_instr(2, 2, 1'b0, 8'h00);
    check("stall_pc", pc_curr, 4'hA);
    run_instr(0, 2, 1'b0, 8'h00);
    check("jmp0_pc", pc_curr, 4'h0);

    // Write to the fetched address in the fetch cycle: old data is captured.
    run_instr(0, 0, 1'b1, 8'h77);
    pc_curr = 4'h0;
    run_instr(0, 0, 1'b0, 8'h00);
    check("write_through_pc", pc_curr, 4'h1);

    // Reset mid-instruction, then resume at the same PC.
    stall = 1'b0;
    #2;
    @(posedge clk); #1;
    check("mid_ir_loaded", ir, ref_mem[pc_curr]);
    do_reset();
    run_instr(0, 2, 1'b0, 8'h00);

    // Random program, random stalls and zero flag.
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++)
      wr(4'(i), {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))});
    do_reset();
    pc_curr = 4'($urandom_range(0, 15));
    for (int n = 0; n < 80; n++) run_instr(1, 2, 1'b0, 8'h00);

`ifdef FETCH_ICOUNT_EN
    for (int n = 0; n < 300; n++) run_instr(0, 2, 1'b0, 8'h00);
    check("icount_saturated", icount, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
- Downstream neighbour of the 4-bit program counter. It consumes the current PC value and fetches the 8-bit instruction at that address from a 16x8 instruction memory.
- It sequences each instruction through a FETCH/DECODE/EXEC state machine and sends advance or jump requests back to the PC stage.
- It is the control front end of the 4-bit CPU. Execute-stage logic consumes opcode, operand and exec_valid.

Parameters:
- IMEM_DEPTH, 16: instruction memory entries. Must equal 2^PC_W.
- PC_W, 4: PC width. Must match the PC stage.
- INSTR_W, 8: instruction width. Upper nibble is the opcode, lower nibble is the operand.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous reset, active low
- pc_curr  input  PC_W  current PC from the PC stage
- zero_flag  input  1  ALU zero flag, sampled in EXEC
- stall  input  1  freezes the FSM and all registers
- imem_we  input  1  instruction memory write enable
- imem_waddr  input  PC_W  instruction memory write address
- imem_wdata  input  INSTR_W  instruction memory write data
- ir  output  INSTR_W  instruction register
- opcode  output  4  equals ir[7:4]
- operand  output  4  equals ir[3:0]
- exec_valid  output  1  one-cycle strobe in EXEC
- pc_step  output  1  one-cycle strobe: PC stage increments
- pc_jump  output  1  one-cycle strobe: PC stage loads pc_target
- pc_target  output  PC_W  jump destination
- halted  output  1  high once HALT has executed

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset state: FSM goes to FETCH. ir, pc_target, exec_valid, pc_step, pc_jump and halted are all 0. Memory contents are not reset.
- Memory write: synchronous, on the rising edge of clk when imem_we=1. Writes are allowed in any state, including during stall.
- Memory read: combinational at pc_curr. If the fetch and a write hit the same address in the same cycle, ir captures the old data.
- States: FETCH -> DECODE -> EXEC -> FETCH, plus HALT. Each state lasts one cycle unless stalled.
- FETCH: ir <= imem[pc_curr].
- DECODE: opcode and operand are stable. No strobes.
- EXEC: exec_valid=1 for this cycle. Action depends on the opcode:
  - 4'hF HALT: no PC strobe. Next state is HALT and halted <= 1.
  - 4'hE JMP: pc_jump=1 and pc_target=operand.
  - 4'hD JZ: if zero_flag=1, pc_jump=1 and pc_target=operand. Otherwise pc_step=1.
  - All other opcodes: pc_step=1.
- Strobe exclusivity: pc_step and pc_jump are never high together. Both are 0 outside EXEC.
- Latency: 3 cycles per instruction. The PC stage updates on the edge that ends EXEC, so the next FETCH sees the new pc_curr.
- PC wrap: stepping from PC 4'hF wraps to 4'h0 in the PC stage. This block simply asserts pc_step.
- stall=1: state, ir and pc_target are held. exec_valid, pc_step and pc_jump are forced to 0.
  - A stall during EXEC defers the strobe. It fires in the first EXEC cycle with stall=0.
- HALT state: sticky. No strobes. ir is held. Only rst_n exits HALT.
- Reset mid-instruction: all state is discarded immediately. Fetch resumes at the current pc_curr.

Optional Feature:
- Macro: FETCH_ICOUNT_EN.
- With the macro defined:
  - Adds output icount, 8 bits: the count of retired instructions (EXEC cycles with exec_valid=1, HALT included).
  - Resets to 0 and saturates at 8'hFF.
- Without the macro: no icount port and no counter logic.

Test Plan:
- Reset, then preload imem[0]=8'h12 and imem[1]=8'h34 with pc_curr=0 → the EXEC cycle shows opcode=4'h1, operand=4'h2, exec_valid=1, pc_step=1, pc_jump=0. The next cycle is FETCH.
- imem[0]=8'hE9 → in EXEC, pc_jump=1, pc_target=4'h9, pc_step=0.
- imem[2]=8'hD5: with zero_flag=1, EXEC gives pc_jump=1 and pc_target=4'h5. With zero_flag=0, EXEC gives pc_step=1.
- imem[3]=8'hF0 → halted=1 after EXEC. No strobes for 20 following cycles. Pulsing rst_n low clears halted and the FSM resumes in FETCH.
- stall held high for 4 cycles starting at EXEC → no strobes while stalled. Exactly one pc_step in the first cycle after stall falls, and ir is unchanged throughout.
- Write imem[0]=8'h77 in the same cycle as the fetch of address 0, which held 8'h12 → ir=8'h12. The next fetch of address 0 returns 8'h77.
- With FETCH_ICOUNT_EN: run 300 non-halt instructions → icount saturates at 8'hFF.
